// File: rtl/pipe_stage_chain.sv
// Valid/payload pipeline chain with stall, hold bubble and flush kill.
// Perf counters: define PIPE_STAGE_CHAIN_PERF_CNT_EN.
module pipe_stage_chain #(
  parameter int DEPTH       = 4,
  parameter int WIDTH       = 46,
  parameter int FLUSH_DEPTH = 2,
  parameter int HOLD_DEPTH  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   stall,
  input  logic                   hold,
  input  logic                   flush,
  output logic                   in_ready,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [31:0]            retire_count,
  output logic [31:0]            bubble_count
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [DEPTH-1:0] nxt_v;
  logic [WIDTH-1:0] nxt_d [DEPTH];
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];

  assign in_ready = ~stall & ~hold & ~reset;

  // Invalid input is zeroed so a bubble never carries write enables.
  assign src_v    = {vld_q[DEPTH-2:0], in_valid};
  assign src_d[0] = in_valid ? in_data : '0;

  for (genvar k = 1; k < DEPTH; k++) begin : g_src
    assign src_d[k] = dat_q[k-1];
  end

  always_comb begin
    logic kill;
    logic keep;
    for (int k = 0; k < DEPTH; k++) begin
      kill = (flush && (k < FLUSH_DEPTH)) ||
             (!stall && hold && (k == HOLD_DEPTH));
      keep = !kill && (stall || (hold && (k < HOLD_DEPTH)));
      nxt_v[k] = src_v[k];
      nxt_d[k] = src_d[k];
      unique case (1'b1)
        kill: begin
          nxt_v[k] = 1'b0;
          nxt_d[k] = '0;
        end
        keep: begin
          nxt_v[k] = vld_q[k];
          nxt_d[k] = dat_q[k];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      dat_q <= '{default: '0};
    end else begin
      vld_q <= nxt_v;
      dat_q <= nxt_d;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign stage_data[k*WIDTH +: WIDTH] = dat_q[k];
  end

  assign stage_valid = vld_q;
  assign out_valid   = vld_q[DEPTH-1];
  assign out_data    = dat_q[DEPTH-1];

`ifdef PIPE_STAGE_CHAIN_PERF_CNT_EN
  logic [31:0] ret_q;
  logic [31:0] bub_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ret_q <= '0;
      bub_q <= '0;
    end else begin
      if (vld_q[DEPTH-1] && !stall)
        ret_q <= ret_q + 32'd1;
      if (hold && !stall && !flush)
        bub_q <= bub_q + 32'd1;
    end
  end

  assign retire_count = ret_q;
  assign bubble_count = bub_q;
`else
  assign retire_count = '0;
  assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed vector bench for pipe_stage_chain (DEPTH=4, WIDTH=46).
// Counter expectations follow PIPE_STAGE_CHAIN_PERF_CNT_EN.
module tb_pipe_stage_chain;

  localparam int W = 46;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           stall;
  logic           hold;
  logic           flush;
  logic           in_ready;
  logic [3:0]     stage_valid;
  logic [4*W-1:0] stage_data;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [31:0]    retire_count;
  logic [31:0]    bubble_count;

  pipe_stage_chain #(
    .DEPTH(4), .WIDTH(W), .FLUSH_DEPTH(2), .HOLD_DEPTH(1)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data),
    .stall(stall), .hold(hold), .flush(flush),
    .in_ready(in_ready),
    .stage_valid(stage_valid), .stage_data(stage_data),
    .out_valid(out_valid), .out_data(out_data),
    .retire_count(retire_count), .bubble_count(bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, iv, st, hd, fl;
    logic [W-1:0] din;
    logic        rdy;
    logic [3:0]  v;
    logic [W-1:0] d0, d1, d2, d3;
    int unsigned ret, bub;
  } vec_t;

  localparam logic [W-1:0] A = 46'h0A, B = 46'h0B, C = 46'h0C;
  localparam logic [W-1:0] D = 46'h0D, E = 46'h0E, F = 46'h0F;
  localparam logic [W-1:0] G = 46'h3FFF_0000_1234, H = 46'h11;
  localparam logic [W-1:0] I = 46'h12, J = 46'h13, K = 46'h14;
  localparam logic [W-1:0] L = 46'h15, M = 46'h16, N = 46'h17;

  int pass_cnt = 0;
  int total = 0;

  function automatic vec_t mk(
    logic rst, logic iv, logic [W-1:0] din,
    logic st, logic hd, logic fl, logic rdy, logic [3:0] v,
    logic [W-1:0] d0, logic [W-1:0] d1,
    logic [W-1:0] d2, logic [W-1:0] d3,
    int unsigned ret, int unsigned bub);
    vec_t r;
    r.rst = rst; r.iv = iv; r.din = din;
    r.st = st; r.hd = hd; r.fl = fl;
    r.rdy = rdy; r.v = v;
    r.d0 = d0; r.d1 = d1; r.d2 = d2; r.d3 = d3;
    r.ret = ret; r.bub = bub;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  vec_t tv [28];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] er, eb;
    tv[0]  = mk(1,1,46'h9,0,0,0, 0,4'b0000, 0,0,0,0, 0,0);
    tv[1]  = mk(0,1,46'h1,0,0,0, 1,4'b0001, 1,0,0,0, 0,0);
    tv[2]  = mk(0,1,46'h2,0,0,0, 1,4'b0011, 2,1,0,0, 0,0);
    tv[3]  = mk(0,1,46'h3,0,0,0, 1,4'b0111, 3,2,1,0, 0,0);
    tv[4]  = mk(0,1,46'h4,0,0,0, 1,4'b1111, 4,3,2,1, 0,0);
    tv[5]  = mk(0,1,46'h5,0,0,0, 1,4'b1111, 5,4,3,2, 1,0);
    tv[6]  = mk(0,0,46'h77,0,0,0,1,4'b1110, 0,5,4,3, 2,0);
    tv[7]  = mk(0,1,A,0,0,0, 1,4'b1101, A,0,5,4, 3,0);
    tv[8]  = mk(0,1,B,0,0,0, 1,4'b1011, B,A,0,5, 4,0);
    tv[9]  = mk(0,1,C,0,0,0, 1,4'b0111, C,B,A,0, 5,0);
    tv[10] = mk(0,1,D,0,0,0, 1,4'b1111, D,C,B,A, 5,0);
    tv[11] = mk(0,1,E,1,0,0, 0,4'b1111, D,C,B,A, 5,0);
    tv[12] = mk(0,1,E,1,0,0, 0,4'b1111, D,C,B,A, 5,0);
    tv[13] = mk(0,1,E,1,0,0, 0,4'b1111, D,C,B,A, 5,0);
    tv[14] = mk(0,1,E,0,0,0, 1,4'b1111, E,D,C,B, 6,0);
    tv[15] = mk(0,1,F,0,1,0, 0,4'b1101, E,0,D,C, 7,1);
    tv[16] = mk(0,1,F,0,0,0, 1,4'b1011, F,E,0,D, 8,1);
    tv[17] = mk(0,1,G,0,0,0, 1,4'b0111, G,F,E,0, 9,1);
    tv[18] = mk(0,1,H,0,0,0, 1,4'b1111, H,G,F,E, 9,1);
    tv[19] = mk(0,1,I,1,0,1, 0,4'b1100, 0,0,F,E, 9,1);
    tv[20] = mk(0,1,I,0,0,0, 1,4'b1001, I,0,0,F, 10,1);
    tv[21] = mk(0,1,J,0,0,0, 1,4'b0011, J,I,0,0, 11,1);
    tv[22] = mk(0,1,K,0,0,0, 1,4'b0111, K,J,I,0, 11,1);
    tv[23] = mk(0,1,L,0,1,1, 0,4'b1100, 0,0,J,I, 11,1);
    tv[24] = mk(0,1,M,0,0,0, 1,4'b1001, M,0,0,J, 12,1);
    tv[25] = mk(0,1,N,0,1,0, 0,4'b0001, M,0,0,0, 13,2);
    tv[26] = mk(1,1,N,0,1,0, 0,4'b0000, 0,0,0,0, 0,0);
    tv[27] = mk(0,1,N,1,1,0, 0,4'b0000, 0,0,0,0, 0,0);

    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    stall = 1'b0; hold = 1'b0; flush = 1'b0;
    #2;

    for (int r = 0; r < 28; r++) begin
      reset = tv[r].rst; in_valid = tv[r].iv; in_data = tv[r].din;
      stall = tv[r].st; hold = tv[r].hd; flush = tv[r].fl;
      #1;
      chk($sformatf("row%0d in_ready", r), 64'(in_ready), 64'(tv[r].rdy));
      @(posedge clk);
      #1;
`ifdef PIPE_STAGE_CHAIN_PERF_CNT_EN
      er = tv[r].ret; eb = tv[r].bub;
`else
      er = '0; eb = '0;
`endif
      chk($sformatf("row%0d valid", r), 64'(stage_valid), 64'(tv[r].v));
      chk($sformatf("row%0d s0", r), 64'(stage_data[0*W +: W]), 64'(tv[r].d0));
      chk($sformatf("row%0d s1", r), 64'(stage_data[1*W +: W]), 64'(tv[r].d1));
      chk($sformatf("row%0d s2", r), 64'(stage_data[2*W +: W]), 64'(tv[r].d2));
      chk($sformatf("row%0d s3", r), 64'(stage_data[3*W +: W]), 64'(tv[r].d3));
      chk($sformatf("row%0d out_valid", r), 64'(out_valid), 64'(tv[r].v[3]));
      chk($sformatf("row%0d out_data", r), 64'(out_data), 64'(tv[r].d3));
      chk($sformatf("row%0d retire", r), 64'(retire_count), 64'(er));
      chk($sformatf("row%0d bubble", r), 64'(bubble_count), 64'(eb));
    end

    // Single-item latency from an empty chain, bounded wait.
    reset = 1'b0; stall = 1'b0; hold = 1'b0; flush = 1'b0;
    in_valid = 1'b1; in_data = 46'h5A;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_data = 46'h3;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'd4);
    chk("latency_data", 64'(out_data), 64'h5A);
    @(posedge clk);
    #1;
    chk("drain_valid", 64'(stage_valid), 64'd0);
    chk("drain_data", 64'(stage_data[3*W +: W]), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of pipeline stages; legal range 2..8.
REQ-002 SHALL have parameter WIDTH, default 46: payload bits per stage, 32-bit instruction plus 14-bit flag bundle.
REQ-003 SHALL have parameter FLUSH_DEPTH, default 2: stages 0..FLUSH_DEPTH-1 are killed by flush; legal range 1..DEPTH.
REQ-004 SHALL have parameter HOLD_DEPTH, default 1: stages 0..HOLD_DEPTH-1 freeze on hold, and stage HOLD_DEPTH receives a bubble; legal range 1..DEPTH-1.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data holds a real instruction.
REQ-008 SHALL have port in_data, input, WIDTH bits: payload entering stage 0.
REQ-009 SHALL have port stall, input, 1 bit: global freeze of all stages.
REQ-010 SHALL have port hold, input, 1 bit: load-use freeze of the lower stages, with a bubble inserted above them.
REQ-011 SHALL have port flush, input, 1 bit: kill the younger stages (taken branch).
REQ-012 SHALL have port in_ready, output, 1 bit: stage 0 accepts in_data this cycle.
REQ-013 SHALL have port stage_valid, output, DEPTH bits: valid bit per stage, where bit k is stage k.
REQ-014 SHALL have port stage_data, output, DEPTH*WIDTH bits: flattened payloads, stage k at bits [k*WIDTH +: WIDTH].
REQ-015 SHALL have port out_valid, output, 1 bit: copy of stage_valid[DEPTH-1].
REQ-016 SHALL have port out_data, output, WIDTH bits: payload of stage DEPTH-1.
REQ-017 SHALL have port retire_count, output, 32 bits: performance counter (see Configuration).
REQ-018 SHALL have port bubble_count, output, 32 bits: performance counter (see Configuration).

Function
REQ-019 SHALL drive in_ready = ~stall & ~hold & ~reset, combinationally.
REQ-020 When stall, flush, hold and reset are all low, each clock SHALL shift the chain: stage 0 <= {in_valid, in_data} and stage k <= stage k-1 for k >= 1.
REQ-021 An invalid stage SHALL hold an all-zero payload, so that a bubble carries no RegWrite or MemWrite.
REQ-022 A valid bit SHALL never be set with a non-zero payload unless it was loaded from in_valid = 1.
REQ-023 When stall = 1, every stage SHALL hold its valid bit and data, except stages killed by flush per REQ-024.
REQ-024 When flush = 1, stages 0..FLUSH_DEPTH-1 SHALL become invalid with zero payload after the edge, regardless of stall, hold or in_valid.
REQ-025 When flush = 1, stages FLUSH_DEPTH..DEPTH-1 SHALL shift (no stall) or hold (stall), as if flush were low.
REQ-026 When hold = 1 and stall = 0, stages 0..HOLD_DEPTH-1 SHALL keep their contents.
REQ-027 When hold = 1 and stall = 0, stage HOLD_DEPTH SHALL become a bubble (invalid, zero payload).
REQ-028 When hold = 1 and stall = 0, stages above HOLD_DEPTH SHALL shift normally.
REQ-029 When stall = 1, hold SHALL be ignored.
REQ-030 Per-stage priority SHALL be reset > flush kill > stall hold > hold freeze/bubble > shift.
REQ-031 When flush and hold are both high, REQ-024 SHALL apply to the stages below FLUSH_DEPTH.
REQ-032 When flush and hold are both high, REQ-026..REQ-028 SHALL apply to the remaining stages.
REQ-033 Latency SHALL be DEPTH cycles from acceptance at stage 0 to appearance on out_data when nothing stalls.
REQ-034 The block SHALL contain no combinational path from in_data to stage_data or out_data.

Reset
REQ-035 While reset = 1 at a rising edge, all stage_valid bits SHALL clear to 0 and all payloads to 0, overriding every other input.
REQ-036 Reset SHALL clear retire_count and bubble_count to 0.
REQ-037 Reset asserted mid-stall or mid-hold SHALL leave no residual state after one edge.

Configuration
REQ-038 The macro PIPE_STAGE_CHAIN_PERF_CNT_EN SHALL compile the performance counters in or out.
REQ-039 With PIPE_STAGE_CHAIN_PERF_CNT_EN defined, retire_count SHALL increment on each edge where stage_valid[DEPTH-1] = 1 and stall = 0.
REQ-040 With PIPE_STAGE_CHAIN_PERF_CNT_EN defined, bubble_count SHALL increment on each edge where hold = 1, stall = 0 and flush = 0.
REQ-041 With PIPE_STAGE_CHAIN_PERF_CNT_EN defined, both counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-042 Without PIPE_STAGE_CHAIN_PERF_CNT_EN, retire_count and bubble_count SHALL be constant 0 and no counter flops SHALL exist.

Verification (DEPTH=4, WIDTH=46, FLUSH_DEPTH=2, HOLD_DEPTH=1)
REQ-043 Bench SHALL cover stream: in_valid=1 with data 1,2,3,4,5 on consecutive cycles -> out_data = 1 on the 4th edge after the first accept, then 2,3,4,5 back to back.
REQ-044 Bench SHALL cover stall: stall=1 for 3 cycles with stages holding A,B,C,D -> stage_data unchanged, in_ready=0; after release, shifting resumes with no loss or duplication.
REQ-045 Bench SHALL cover hold: one hold cycle with stage0=X, stage1=Y -> stage0 still X, stage1 invalid/zero, stage2=Y; bubble_count +1 (macro defined).
REQ-046 Bench SHALL cover flush with stall: stages valid 1111 -> stage_valid = 1100 (stages 0,1 killed), stages 2,3 unchanged.
REQ-047 Bench SHALL cover flush with hold, no stall: stages 0,1 killed, stages 2 and 3 shifted; bubble_count unchanged.
REQ-048 Bench SHALL cover reset mid-hold, with hold and in_valid high -> all valid=0, payloads 0, counters 0 after one edge; with the macro undefined, counters read 0 throughout.
